// File: rtl/fan_temp_ctrl_mc.sv
// fan_temp_ctrl_mc
// Multi-channel fan speed controller. Samples N_CH packed 8-bit temperature
// channels on an internal periodic tick, takes the maximum of the enabled
// channels and steps a fan level up/down one step per sample with
// hysteresis. Spin-up, critical-temperature force-max, sensor-lost and
// (optionally) stall detection are handled by a small three-state FSM.
//
// Optional feature macro: FAN_STALL_DET_EN
//   defined   : stall counter watches FAN_RPM against SPEED_RPM/2 and raises
//               the sticky FAN_FAIL flag after STALL_SAMPLES low samples.
//   undefined : FAN_FAIL is tied low and FAN_RPM is ignored.
//
// Pipeline per sample tick (cycle T = SAMPLE_TICK high):
//   edge ending T   : TEMP_MAX / SENSOR_LOST captured
//   edge ending T+1 : FSM decision (state, LEV, TEMP_CRIT, stall flag)
//   edge ending T+2 : SPEED_RPM / FAN_DAC follow LEV
//
// Handshake: none. Inputs are sampled only on the tick; there is no
// valid/ready traffic on this block. DBG_STATE exposes the FSM state
// (0 = SPINUP, 1 = RUN, 2 = FORCE) for checkers.

module fan_temp_ctrl_mc #(
   parameter int N_CH           = 2,
   parameter int NLEV           = 7,
   parameter int T_BASE         = 30,
   parameter int T_STEP         = 5,
   parameter int HYST           = 3,
   parameter int T_CRIT         = 60,
   parameter int RPM_MIN        = 3000,
   parameter int RPM_STEP       = 500,
   parameter int DAC_MIN        = 64,
   parameter int DAC_STEP       = 32,
   parameter int SAMPLE_DIV     = 20000,
   parameter int SPINUP_SAMPLES = 2,
   parameter int STALL_SAMPLES  = 3
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [8*N_CH-1:0]   TEMP_IN,
   input  logic [N_CH-1:0]     CH_EN,
   input  logic [15:0]         FAN_RPM,
   output logic                SAMPLE_TICK,
   output logic [7:0]          TEMP_MAX,
   output logic [3:0]          LEV,
   output logic [15:0]         SPEED_RPM,
   output logic [7:0]          FAN_DAC,
   output logic                TEMP_CRIT,
   output logic                SENSOR_LOST,
   output logic                FAN_FAIL,
   output logic                FORCE_MAX,
   output logic [1:0]          DBG_STATE
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SPIN_W    = (SPINUP_SAMPLES > 1) ? $clog2(SPINUP_SAMPLES + 1) : 1;
   localparam int SPIN_LAST = (SPINUP_SAMPLES > 0) ? SPINUP_SAMPLES - 1 : 0;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [SPIN_W-1:0] SPIN_END = SPIN_W'(SPIN_LAST);
   localparam logic [3:0]        LEV_MAX  = 4'(NLEV - 1);

   // All temperature compares are done in 10 bits so 255 + HYST cannot wrap.
   localparam logic [9:0] C_BASE = 10'(T_BASE);
   localparam logic [9:0] C_STEP = 10'(T_STEP);
   localparam logic [9:0] C_HYST = 10'(HYST);
   localparam logic [9:0] C_CRIT = 10'(T_CRIT);

   typedef enum logic [1:0] {
      ST_SPINUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_FORCE  = 2'd2
   } state_t;

   // Target RPM for a level, truncated to 16 bits.
   function automatic logic [15:0] f_rpm(input logic [3:0] lev);
      return 16'(RPM_MIN) + 16'(lev) * 16'(RPM_STEP);
   endfunction

   // DAC code for a level, saturating at 255.
   function automatic logic [7:0] f_dac(input logic [3:0] lev);
      logic [15:0] sum;
      sum = 16'(DAC_MIN) + 16'(lev) * 16'(DAC_STEP);
      return (sum > 16'd255) ? 8'hFF : sum[7:0];
   endfunction

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [DIV_W-1:0]  r_div;
   logic              r_dec;          // decision strobe, one cycle after the tick
   logic [7:0]        r_temp_max;
   logic              r_sensor_lost;
   logic              r_temp_crit;
   logic [3:0]        r_lev;
   logic [15:0]       r_speed_rpm;
   logic [7:0]        r_fan_dac;
   logic [SPIN_W-1:0] r_spin;
   state_t            r_state;

   logic              w_tick;
   logic [7:0]        w_max;
   logic              w_any_en;
   logic [9:0]        w_t10;
   logic [9:0]        w_thr_up;
   logic [9:0]        w_thr_dn;
   logic              w_up;
   logic              w_dn;
   logic              w_crit_nxt;
   logic              w_fail_nxt;
   logic              w_fail;
   logic              w_force;
   state_t            w_state_nxt;
   logic [3:0]        w_lev_nxt;
   logic [SPIN_W-1:0] w_spin_nxt;

   // ------------------------------------------------------------------
   // Sample divider
   // ------------------------------------------------------------------
   assign w_tick = (r_div == DIV_LAST);

   // Free-running 0..SAMPLE_DIV-1 counter plus the delayed decision strobe.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_div <= '0;
         r_dec <= 1'b0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         r_dec <= w_tick;
      end
   end

   // ------------------------------------------------------------------
   // Channel maximum
   // ------------------------------------------------------------------
   // Max over enabled channels; stays 0 when nothing is enabled.
   always_comb begin
      w_max    = 8'd0;
      w_any_en = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (CH_EN[k]) begin
            w_any_en = 1'b1;
            if (TEMP_IN[8*k +: 8] > w_max) begin
               w_max = TEMP_IN[8*k +: 8];
            end
         end
      end
   end

   // Capture the channel maximum and the sensor-lost flag on the tick.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_temp_max    <= 8'd0;
         r_sensor_lost <= 1'b0;
      end else if (w_tick) begin
         r_temp_max    <= w_max;
         r_sensor_lost <= ~w_any_en;
      end
   end

   // ------------------------------------------------------------------
   // Threshold compares (decision cycle uses the registered maximum)
   // ------------------------------------------------------------------
   assign w_t10    = {2'b00, r_temp_max};
   assign w_thr_up = C_BASE + 10'(r_lev) * C_STEP;
   // Only meaningful when r_lev > 0; w_dn masks the wrapped value at level 0.
   assign w_thr_dn = C_BASE + 10'(r_lev - 4'd1) * C_STEP;
   assign w_up     = (w_t10 > w_thr_up) && (r_lev < LEV_MAX);
   assign w_dn     = (r_lev != 4'd0) && ((w_t10 + C_HYST) <= w_thr_dn);

   // Critical flag with hysteresis; the next value feeds the force condition
   // so a new critical reading forces max in the same decision.
   assign w_crit_nxt = r_temp_crit ? ~((w_t10 + C_HYST) <= C_CRIT)
                                   : (w_t10 > C_CRIT);

   // Update the critical flag on each decision.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_temp_crit <= 1'b0;
      end else if (r_dec) begin
         r_temp_crit <= w_crit_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Stall detection
   // ------------------------------------------------------------------
`ifdef FAN_STALL_DET_EN
   localparam int STALL_W = (STALL_SAMPLES > 1) ? $clog2(STALL_SAMPLES + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_END = STALL_W'(STALL_SAMPLES);

   logic [STALL_W-1:0] r_stall;
   logic [STALL_W-1:0] w_stall_nxt;
   logic               r_fan_fail;

   // Count consecutive low-RPM decisions outside spin-up; FAN_FAIL is sticky.
   always_comb begin
      w_stall_nxt = r_stall;
      w_fail_nxt  = r_fan_fail;
      if (r_dec && (r_state != ST_SPINUP)) begin
         if (FAN_RPM < (r_speed_rpm >> 1)) begin
            if (r_stall < STALL_END) begin
               w_stall_nxt = r_stall + STALL_W'(1);
            end
         end else begin
            w_stall_nxt = '0;
         end
         if (w_stall_nxt >= STALL_END) begin
            w_fail_nxt = 1'b1;
         end
      end
   end

   // Stall counter and sticky failure flag.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_stall    <= '0;
         r_fan_fail <= 1'b0;
      end else begin
         r_stall    <= w_stall_nxt;
         r_fan_fail <= w_fail_nxt;
      end
   end

   assign w_fail = r_fan_fail;
`else
   logic w_unused_rpm;

   assign w_unused_rpm = ^FAN_RPM;
   assign w_fail_nxt   = 1'b0;
   assign w_fail       = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Level FSM
   // ------------------------------------------------------------------
   assign w_force = w_crit_nxt | r_sensor_lost | w_fail_nxt;

   // Next state / level. Leaving FORCE keeps LEV at max for that decision;
   // the normal one-step ramp starts at the following decision.
   always_comb begin
      w_state_nxt = r_state;
      w_lev_nxt   = r_lev;
      w_spin_nxt  = r_spin;
      if (r_dec) begin
         case (r_state)
            ST_SPINUP: begin
               w_lev_nxt = LEV_MAX;
               if (r_spin >= SPIN_END) begin
                  w_state_nxt = w_force ? ST_FORCE : ST_RUN;
               end else begin
                  w_spin_nxt = r_spin + SPIN_W'(1);
               end
            end
            ST_RUN: begin
               if (w_force) begin
                  w_state_nxt = ST_FORCE;
                  w_lev_nxt   = LEV_MAX;
               end else if (w_up) begin
                  w_lev_nxt = r_lev + 4'd1;
               end else if (w_dn) begin
                  w_lev_nxt = r_lev - 4'd1;
               end
            end
            ST_FORCE: begin
               w_lev_nxt = LEV_MAX;
               if (!w_force) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_SPINUP;
               w_lev_nxt   = LEV_MAX;
            end
         endcase
      end
   end

   // FSM state, level and spin-up counter registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_SPINUP;
         r_lev   <= LEV_MAX;
         r_spin  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lev   <= w_lev_nxt;
         r_spin  <= w_spin_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Output stage: RPM / DAC trail LEV by one clock
   // ------------------------------------------------------------------
   // Re-register the speed targets from the current level every clock.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_speed_rpm <= f_rpm(LEV_MAX);
         r_fan_dac   <= f_dac(LEV_MAX);
      end else begin
         r_speed_rpm <= f_rpm(r_lev);
         r_fan_dac   <= f_dac(r_lev);
      end
   end

   assign SAMPLE_TICK = w_tick;
   assign TEMP_MAX    = r_temp_max;
   assign LEV         = r_lev;
   assign SPEED_RPM   = r_speed_rpm;
   assign FAN_DAC     = r_fan_dac;
   assign TEMP_CRIT   = r_temp_crit;
   assign SENSOR_LOST = r_sensor_lost;
   assign FAN_FAIL    = w_fail;
   assign FORCE_MAX   = (r_state == ST_SPINUP) || (r_state == ST_FORCE);
   assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_fan_temp_ctrl_mc.sv
// Directed testbench for fan_temp_ctrl_mc (SAMPLE_DIV shortened to 8).
// Optional stall checks follow FAN_STALL_DET_EN.

module tb_fan_temp_ctrl_mc;

   localparam int DIV = 8;

   logic        CLK;
   logic        RESET_N;
   logic [15:0] TEMP_IN;
   logic [1:0]  CH_EN;
   logic [15:0] FAN_RPM;
   logic        SAMPLE_TICK;
   logic [7:0]  TEMP_MAX;
   logic [3:0]  LEV;
   logic [15:0] SPEED_RPM;
   logic [7:0]  FAN_DAC;
   logic        TEMP_CRIT;
   logic        SENSOR_LOST;
   logic        FAN_FAIL;
   logic        FORCE_MAX;
   logic [1:0]  DBG_STATE;

   int checks = 0;
   int errors = 0;

   fan_temp_ctrl_mc #(
      .N_CH       (2),
      .SAMPLE_DIV (DIV)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .TEMP_IN     (TEMP_IN),
      .CH_EN       (CH_EN),
      .FAN_RPM     (FAN_RPM),
      .SAMPLE_TICK (SAMPLE_TICK),
      .TEMP_MAX    (TEMP_MAX),
      .LEV         (LEV),
      .SPEED_RPM   (SPEED_RPM),
      .FAN_DAC     (FAN_DAC),
      .TEMP_CRIT   (TEMP_CRIT),
      .SENSOR_LOST (SENSOR_LOST),
      .FAN_FAIL    (FAN_FAIL),
      .FORCE_MAX   (FORCE_MAX),
      .DBG_STATE   (DBG_STATE)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the negedge at which SAMPLE_TICK is high.
   task automatic find_tick();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 4 * DIV; i++) begin
         @(negedge CLK);
         if (SAMPLE_TICK) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      assert (got) else begin
         errors++;
         $error("FAIL tick_timeout observed=0 expected=1");
      end
   endtask

   // From the tick negedge to the negedge after the decision edge.
   task automatic post_tick();
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic tick_lev();
      find_tick();
      post_tick();
   endtask

   // One full sample: level after decision, RPM/DAC one clock later.
   task automatic step(input string tag, input int e_lev, input int e_rpm, input int e_dac);
      tick_lev();
      chk({tag, "_lev"}, 32'(LEV), e_lev);
      @(negedge CLK);
      chk({tag, "_rpm"}, 32'(SPEED_RPM), e_rpm);
      chk({tag, "_dac"}, 32'(FAN_DAC), e_dac);
   endtask

   initial begin
      int n;
      int e_fail;
      int e_slev;

      // reset state
      RESET_N = 1'b0;
      TEMP_IN = {8'd40, 8'd35};
      CH_EN   = 2'b11;
      FAN_RPM = 16'd6000;
      #23;
      chk("rst_lev",   32'(LEV), 6);
      chk("rst_rpm",   32'(SPEED_RPM), 6000);
      chk("rst_dac",   32'(FAN_DAC), 255);
      chk("rst_tmax",  32'(TEMP_MAX), 0);
      chk("rst_crit",  32'(TEMP_CRIT), 0);
      chk("rst_lost",  32'(SENSOR_LOST), 0);
      chk("rst_fail",  32'(FAN_FAIL), 0);
      chk("rst_tick",  32'(SAMPLE_TICK), 0);
      chk("rst_force", 32'(FORCE_MAX), 1);
      chk("rst_state", 32'(DBG_STATE), 0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // spin-up: two samples held at max
      tick_lev();
      chk("su1_tmax",  32'(TEMP_MAX), 40);
      chk("su1_force", 32'(FORCE_MAX), 1);
      chk("su1_lev",   32'(LEV), 6);
      chk("su1_tick",  32'(SAMPLE_TICK), 0);
      @(negedge CLK);
      chk("su1_rpm",   32'(SPEED_RPM), 6000);
      tick_lev();
      chk("su2_force", 32'(FORCE_MAX), 0);
      chk("su2_state", 32'(DBG_STATE), 1);
      chk("su2_lev",   32'(LEV), 6);
      @(negedge CLK);

      // first ramp step: LEV moves one clock before RPM/DAC
      tick_lev();
      chk("r5_lev",     32'(LEV), 5);
      chk("r5_rpm_old", 32'(SPEED_RPM), 6000);
      @(negedge CLK);
      chk("r5_rpm", 32'(SPEED_RPM), 5500);
      chk("r5_dac", 32'(FAN_DAC), 224);
      step("r4", 4, 5000, 192);
      step("r3", 3, 4500, 160);
      step("hold3", 3, 4500, 160);

      // step-up boundary: 45 is not above 45
      TEMP_IN = {8'd45, 8'd35};
      step("up_edge", 3, 4500, 160);
      chk("up_edge_tmax", 32'(TEMP_MAX), 45);
      TEMP_IN = {8'd46, 8'd35};
      step("up4", 4, 5000, 192);
      // down needs T+3 <= 45: 43 holds, 42 steps down
      TEMP_IN = {8'd43, 8'd35};
      step("hyst_hold", 4, 5000, 192);
      TEMP_IN = {8'd42, 8'd35};
      step("dn3", 3, 4500, 160);

      // critical: set above 60, clear only at T+3 <= 60
      TEMP_IN = {8'd42, 8'd61};
      step("crit", 6, 6000, 255);
      chk("crit_flag",  32'(TEMP_CRIT), 1);
      chk("crit_force", 32'(FORCE_MAX), 1);
      chk("crit_state", 32'(DBG_STATE), 2);
      chk("crit_tmax",  32'(TEMP_MAX), 61);
      TEMP_IN = {8'd42, 8'd58};
      step("crit58", 6, 6000, 255);
      chk("crit58_flag",  32'(TEMP_CRIT), 1);
      chk("crit58_state", 32'(DBG_STATE), 2);
      TEMP_IN = {8'd42, 8'd57};
      step("crit57", 6, 6000, 255);
      chk("crit57_flag",  32'(TEMP_CRIT), 0);
      chk("crit57_force", 32'(FORCE_MAX), 0);
      TEMP_IN = {8'd42, 8'd35};
      step("crit_ramp", 5, 5500, 224);

      // sensor lost
      CH_EN = 2'b00;
      step("lost", 6, 6000, 255);
      chk("lost_flag",  32'(SENSOR_LOST), 1);
      chk("lost_tmax",  32'(TEMP_MAX), 0);
      chk("lost_force", 32'(FORCE_MAX), 1);
      // changes between ticks have no effect yet
      CH_EN   = 2'b01;
      TEMP_IN = {8'd42, 8'd32};
      @(negedge CLK);
      chk("between_tmax", 32'(TEMP_MAX), 0);
      chk("between_lost", 32'(SENSOR_LOST), 1);
      step("recover", 6, 6000, 255);
      chk("recover_lost",  32'(SENSOR_LOST), 0);
      chk("recover_tmax",  32'(TEMP_MAX), 32);
      chk("recover_state", 32'(DBG_STATE), 1);
      step("d5", 5, 5500, 224);
      step("d4", 4, 5000, 192);
      step("d3", 3, 4500, 160);
      step("d2", 2, 4000, 128);
      step("d1", 1, 3500, 96);
      step("d1_hold", 1, 3500, 96);

      // only channel 1 enabled; reach level 0 and hold there
      CH_EN   = 2'b10;
      TEMP_IN = {8'd20, 8'd32};
      step("l0", 0, 3000, 64);
      chk("l0_tmax", 32'(TEMP_MAX), 20);
      step("l0_hold", 0, 3000, 64);
      CH_EN   = 2'b11;
      TEMP_IN = {8'd40, 8'd35};
      step("l1_up", 1, 3500, 96);

      // asynchronous reset between ticks
      @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_lev",   32'(LEV), 6);
      chk("arst_rpm",   32'(SPEED_RPM), 6000);
      chk("arst_dac",   32'(FAN_DAC), 255);
      chk("arst_tmax",  32'(TEMP_MAX), 0);
      chk("arst_force", 32'(FORCE_MAX), 1);
      chk("arst_state", 32'(DBG_STATE), 0);
      chk("arst_tick",  32'(SAMPLE_TICK), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      n = 0;
      for (int i = 0; i < 4 * DIV; i++) begin
         @(negedge CLK);
         n++;
         if (SAMPLE_TICK) break;
      end
      chk("arst_div_restart", n, DIV - 1);
      post_tick();
      chk("arst_su1_lev",   32'(LEV), 6);
      chk("arst_su1_force", 32'(FORCE_MAX), 1);
      @(negedge CLK);
      step("arst_su2", 6, 6000, 255);
      step("arst_r5", 5, 5500, 224);
      step("arst_r4", 4, 5000, 192);
      step("arst_r3", 3, 4500, 160);

      // stall: FAN_RPM below half of 4500 for three samples
      FAN_RPM = 16'd2000;
      step("stall1", 3, 4500, 160);
      step("stall2", 3, 4500, 160);
      chk("stall2_fail", 32'(FAN_FAIL), 0);
`ifdef FAN_STALL_DET_EN
      e_fail = 1;
      e_slev = 6;
`else
      e_fail = 0;
      e_slev = 3;
`endif
      step("stall3", e_slev, (e_slev == 6) ? 6000 : 4500, (e_slev == 6) ? 255 : 160);
      chk("stall3_fail", 32'(FAN_FAIL), e_fail);
      FAN_RPM = 16'd6000;
      step("sticky", e_slev, (e_slev == 6) ? 6000 : 4500, (e_slev == 6) ? 255 : 160);
      chk("sticky_fail",  32'(FAN_FAIL), e_fail);
      chk("sticky_force", 32'(FORCE_MAX), e_fail);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      chk("fail_cleared", 32'(FAN_FAIL), 0);
      @(negedge CLK);
      RESET_N = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
